// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// start-glitch rejection, break handling and a one-entry valid/ready holding register.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] outData,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err
);
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, next_state;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [3:0]       s, s_next;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             v7, v8, maj;
    logic             start_edge, commit, frame_pulse, shift_en;

    assign tick       = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign s_next     = s + 4'd1;
    assign maj        = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign busy       = (state != IDLE) && (state != BREAK);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Bit events fire on the tick that moves s to the named value.
    always_comb begin
        next_state  = state;
        commit      = 1'b0;
        frame_pulse = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: if (start_edge) next_state = START;
            START: begin
                if (tick && s_next == 4'd9 && maj)  next_state = IDLE;
                else if (tick && s_next == 4'd15)   next_state = DATA;
            end
            DATA: begin
                if (tick && s_next == 4'd9) shift_en = 1'b1;
                if (tick && s_next == 4'd15 && idx == 3'd7) next_state = STOP;
            end
            STOP: begin
                if (tick && s_next == 4'd9) begin
                    if (maj) begin
                        commit     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        frame_pulse = 1'b1;
                        next_state  = BREAK;
                    end
                end
            end
            BREAK: if (tick && rx_s && s == 4'd15) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            tick_cnt    <= '0;
            s           <= '0;
            idx         <= '0;
            shreg       <= '0;
            v7          <= 1'b0;
            v8          <= 1'b0;
            outData     <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            if (start_edge || tick) tick_cnt <= '0;
            else                    tick_cnt <= tick_cnt + CNT_W'(1);

            // In BREAK, s counts consecutive high ticks instead of bit phase.
            if (start_edge || frame_pulse) s <= '0;
            else if (tick) begin
                if (state == BREAK) s <= rx_s ? s_next : 4'd0;
                else                s <= s_next;
            end

            if (tick && s_next == 4'd7) v7 <= rx_s;
            if (tick && s_next == 4'd8) v8 <= rx_s;

            if (start_edge) idx <= '0;
            else if (state == DATA && tick && s_next == 4'd15) idx <= idx + 3'd1;

            if (shift_en) shreg[idx] <= maj;

            frame_err   <= frame_pulse;
            overrun_err <= commit && out_valid && !out_ready;
            if (commit) begin
                outData   <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run with a short tick divider (4 clocks/tick,
// 64 clocks per bit) so every scenario fits in a few thousand cycles.
module tb_uart_rx;
    localparam int BIT_NS = 640;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] outData;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;

    int  tests = 0;
    int  fails = 0;
    int  vld_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int  vld_b, fe_b, ov_b;
    logic vld_q = 1'b0;
    time vld_time = 0;
    time frame_t0 = 0;
    time lat;

    uart_rx #(.CLK_FREQ(100_000_000), .BAUD(1_562_500)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .rx         (rx),
        .outData    (outData),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        vld_q <= out_valid;
        if (out_valid && !vld_q) begin
            vld_cnt  <= vld_cnt + 1;
            vld_time <= $time;
        end
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if (overrun_err) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        frame_t0 = $time;
        rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #BIT_NS;
        end
        rx = stop_bit;
        #BIT_NS;
    endtask

    task automatic snap();
        vld_b = vld_cnt;
        fe_b  = fe_cnt;
        ov_b  = ov_cnt;
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; out_ready = 1'b0;
        #500;
        check("rst_outData", outData, 8'h00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        #500;
        rst_n = 1'b1;
        snap();
        #2000;
        check("idle_valid_cnt", vld_cnt - vld_b, 0);
        check("idle_fe_cnt", fe_cnt - fe_b, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_outData", outData, 8'h00);

        // Single byte, consumer always ready; commit edge lands 25 ns + 153 ticks after the pin edge.
        out_ready = 1'b1;
        snap();
        fork
            send_byte(8'h96, 1'b1);
            begin
                #(5 * BIT_NS);
                check("single_busy_mid", busy, 1'b1);
            end
        join
        #BIT_NS;
        check("single_valid_cnt", vld_cnt - vld_b, 1);
        check("single_outData", outData, 8'h96);
        check("single_valid_cleared", out_valid, 1'b0);
        check("single_fe", fe_cnt - fe_b, 0);
        check("single_ov", ov_cnt - ov_b, 0);
        check("single_busy_end", busy, 1'b0);
        lat = vld_time - frame_t0;
        tests++;
        assert (lat >= 6130 && lat <= 6170) else begin
            fails++;
            $error("FAIL single_latency: observed %0t expected 6150 +/- 20", lat);
        end

        // Two frames with the consumer stalled: second byte overwrites, one overrun.
        out_ready = 1'b0;
        snap();
        send_byte(8'h96, 1'b1);
        send_byte(8'h35, 1'b1);
        #BIT_NS;
        check("bp_outData", outData, 8'h35);
        check("bp_valid", out_valid, 1'b1);
        check("bp_ov_cnt", ov_cnt - ov_b, 1);
        check("bp_valid_rises", vld_cnt - vld_b, 1);
        @(negedge clk_100MHz) out_ready = 1'b1;
        @(negedge clk_100MHz) out_ready = 1'b0;
        check("bp_valid_after_ack", out_valid, 1'b0);
        check("bp_outData_held", outData, 8'h35);

        // Short low pulse on the line must not be taken as a start bit.
        snap();
        #100;
        rx = 1'b0;
        #100;
        check("glitch_busy_start", busy, 1'b1);
        rx = 1'b1;
        #(2 * BIT_NS);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_valid_cnt", vld_cnt - vld_b, 0);
        check("glitch_fe", fe_cnt - fe_b, 0);

        // Low stop bit followed by a held-low line, then a good frame.
        out_ready = 1'b1;
        snap();
        send_byte(8'h35, 1'b0);
        #(5 * BIT_NS);
        check("brk_fe_cnt", fe_cnt - fe_b, 1);
        check("brk_busy", busy, 1'b0);
        check("brk_valid_cnt", vld_cnt - vld_b, 0);
        rx = 1'b1;
        #(3 * BIT_NS);
        send_byte(8'hA5, 1'b1);
        #BIT_NS;
        check("brk_next_outData", outData, 8'hA5);
        check("brk_next_valid_cnt", vld_cnt - vld_b, 1);
        check("brk_fe_total", fe_cnt - fe_b, 1);

        // Reset during data bit 4 of 0x96, then a clean 0x35.
        snap();
        rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 8'h01;
            #BIT_NS;
        end
        rx = 1'b1;
        #(BIT_NS / 2);
        check("mid_busy_pre_rst", busy, 1'b1);
        rst_n = 1'b0;
        #10;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_outData", outData, 8'h00);
        #990;
        rst_n = 1'b1;
        #(2 * BIT_NS);
        send_byte(8'h35, 1'b1);
        #BIT_NS;
        check("mid_outData", outData, 8'h35);
        check("mid_valid_cnt", vld_cnt - vld_b, 1);
        check("mid_fe", fe_cnt - fe_b, 0);
        check("mid_ov", ov_cnt - ov_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
